// File: rtl/sha256_compress_core_if.sv
// Block/chaining-value input and digest output bundle for sha256_compress_core.
// Word 0 of hi/blk/ho sits in the most significant position, so hi[0] is H0.
interface sha256_compress_core_if;
  logic              in_valid;
  logic              in_ready;
  logic [0:7][31:0]  hi;
  logic [0:15][31:0] blk;
  logic              dbl;
  logic              out_valid;
  logic              out_ready;
  logic [0:7][31:0]  ho;
  logic [7:0]        out_lane;

  modport master (
    output in_valid, hi, blk, dbl, out_ready,
    input  in_ready, out_valid, ho, out_lane
  );

  modport slave (
    input  in_valid, hi, blk, dbl, out_ready,
    output in_ready, out_valid, ho, out_lane
  );
endinterface

// File: rtl/sha256_compress_core.sv
// SHA-256 compression engine: RPC rounds per clock with a 16-word sliding message window.
// Define SHA256_DOUBLE_EN to honour dbl (second pass over the 256-bit first digest).
module sha256_compress_core #(
  parameter int unsigned RPC     = 1,
  parameter int unsigned LANE_ID = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  sha256_compress_core_if.slave   bus
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_rpc_check
    $error("sha256_compress_core: RPC must be 1, 2, 4 or 8 (got %0d)", RPC);
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_R2SETUP,
    S_DONE
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_t            state, state_nxt;
  logic [0:7][31:0]  hi_q, st_q, st_nxt, ho_q;
  logic [0:15][31:0] win_q, win_nxt;
  logic [6:0]        t_q;
  logic              last_round;
  logic              in_ready_c, out_valid_c;

`ifdef SHA256_DOUBLE_EN
  logic              dbl_q;
`else
  logic              dbl_unused;
  assign dbl_unused = bus.dbl;
`endif

  assign last_round = (t_q == 7'(64 - RPC));

  // RPC rounds chained combinationally; the window always presents W_t at index 0.
  always_comb begin
    logic [31:0]       a, b, c, d, e, f, g, h;
    logic [31:0]       t1, t2, w_new;
    logic [5:0]        kidx;
    logic [0:15][31:0] w;
    a = st_q[0]; b = st_q[1]; c = st_q[2]; d = st_q[3];
    e = st_q[4]; f = st_q[5]; g = st_q[6]; h = st_q[7];
    w     = win_q;
    t1    = '0;
    t2    = '0;
    w_new = '0;
    kidx  = '0;
    for (int unsigned r = 0; r < RPC; r++) begin
      kidx  = t_q[5:0] + 6'(r);
      t1    = h + big_s1(e) + ((e & f) ^ (~e & g)) + K[kidx] + w[0];
      t2    = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
      w_new = w[0] + small_s0(w[1]) + w[9] + small_s1(w[14]);
      w     = {w[1:15], w_new};
    end
    st_nxt  = {a, b, c, d, e, f, g, h};
    win_nxt = w;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // in_ready is gated by reset so it reads low during the reset cycle itself.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready_c = !reset;
        if (bus.in_valid) state_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (last_round) state_nxt = S_FINAL;
      end
      S_FINAL: begin
`ifdef SHA256_DOUBLE_EN
        state_nxt = dbl_q ? S_R2SETUP : S_DONE;
`else
        state_nxt = S_DONE;
`endif
      end
      S_R2SETUP: state_nxt = S_ROUND;
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q   <= '0;
      ho_q  <= '0;
      hi_q  <= '0;
      st_q  <= '0;
      win_q <= '0;
`ifdef SHA256_DOUBLE_EN
      dbl_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            hi_q  <= bus.hi;
            st_q  <= bus.hi;
            win_q <= bus.blk;
`ifdef SHA256_DOUBLE_EN
            dbl_q <= bus.dbl;
`endif
          end
        end
        S_ROUND: begin
          st_q  <= st_nxt;
          win_q <= win_nxt;
          t_q   <= last_round ? '0 : t_q + 7'(RPC);
        end
        S_FINAL: begin
          for (int unsigned i = 0; i < 8; i++) ho_q[i] <= hi_q[i] + st_q[i];
        end
`ifdef SHA256_DOUBLE_EN
        // Second pass: the first digest becomes a single padded 256-bit message.
        S_R2SETUP: begin
          hi_q  <= IV;
          st_q  <= IV;
          win_q <= {ho_q, 32'h8000_0000, {6{32'h0000_0000}}, 32'd256};
          dbl_q <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.ho        = ho_q;
  assign bus.out_lane  = 8'(LANE_ID);

endmodule
